// File: rtl/fsm_pattern_gen.sv
// rtl/fsm_pattern_gen.sv - programmable 1-0-1-0 framing generator for the sequence detector
module fsm_pattern_gen #(
    parameter int HOLD_W = 4,
    parameter int REP_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic [REP_W-1:0]  repeat_cnt,
    output logic              a_out,
    output logic              busy,
    output logic              done,
    output logic [REP_W-1:0]  frame_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_START = 3'd1,
        P_STOP  = 3'd2,
        P_CLEAR = 3'd3,
        P_TAIL  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [REP_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              a_out_q, a_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              phase_end;

    assign phase_end = (cnt_q == hold_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        frame_cnt_d = frame_cnt_q;
        a_out_d     = a_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                a_out_d = 1'b0;
                busy_d  = 1'b0;
                if (start && !abort) begin
                    hold_d      = hold_len;
                    rep_d       = repeat_cnt;
                    frame_cnt_d = '0;
                    cnt_d       = '0;
                    state_d     = P_START;
                    a_out_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            P_START, P_STOP, P_CLEAR, P_TAIL: begin
                // abort wins over both the phase advance and the frame bookkeeping
                if (abort) begin
                    state_d = IDLE;
                    a_out_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (phase_end) begin
                    cnt_d = '0;
                    case (state_q)
                        P_START: begin
                            state_d = P_STOP;
                            a_out_d = 1'b0;
                        end
                        P_STOP: begin
                            state_d = P_CLEAR;
                            a_out_d = 1'b1;
                        end
                        P_CLEAR: begin
                            state_d = P_TAIL;
                            a_out_d = 1'b0;
                        end
                        default: begin
                            frame_cnt_d = frame_cnt_q + REP_W'(1);
                            if (frame_cnt_q == rep_q) begin
                                state_d = IDLE;
                                a_out_d = 1'b0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = P_START;
                                a_out_d = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                a_out_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            cnt_q       <= '0;
            rep_q       <= '0;
            frame_cnt_q <= '0;
            a_out_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            frame_cnt_q <= frame_cnt_d;
            a_out_q     <= a_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_out     = a_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fsm_pattern_gen.sv
// tb/tb_fsm_pattern_gen.sv - randomized self-checking bench for fsm_pattern_gen
module tb_fsm_pattern_gen;

    localparam int HOLD_W = 4;
    localparam int REP_W  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [HOLD_W-1:0] hold_len = '0;
    logic [REP_W-1:0]  repeat_cnt = '0;
    logic              a_out;
    logic              busy;
    logic              done;
    logic [REP_W-1:0]  frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fsm_pattern_gen #(.HOLD_W(HOLD_W), .REP_W(REP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .hold_len   (hold_len),
        .repeat_cnt (repeat_cnt),
        .a_out      (a_out),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clock = ~clock;

    // Burst model: cycle k counts from the first cycle after the accepting edge.
    // Within a burst the line is 1 in even phases, 0 in odd phases; a frame is
    // four phases of h+1 cycles. k_ab is the cycle during which abort is held.
    // noise: 0 quiet, 1 random start/config churn, 2 constant start with hold_len=7.
    task automatic exercise_burst(input int h, input int r, input int k_ab, input int noise, input string name);
        int flen, total, quiet, last, busy_n, done_n;
        logic ea, eb, ed;
        logic [REP_W-1:0] efc;
        flen  = 4 * (h + 1);
        total = (r + 1) * flen;
        quiet = (k_ab >= 0) ? k_ab : total;
        last  = (k_ab >= 0) ? k_ab + 1 : total + 1;
        busy_n = 0;
        done_n = 0;
        hold_len   = HOLD_W'(h);
        repeat_cnt = REP_W'(r);
        start = 1'b1;
        abort = 1'b0;
        @(negedge clock);
        for (int k = 0; k <= last; k++) begin
            if (k_ab >= 0 && k > k_ab) begin
                ea = 1'b0; eb = 1'b0; ed = 1'b0; efc = REP_W'(k_ab / flen);
            end else if (k < total) begin
                ea = (((k % flen) / (h + 1)) % 2) == 0;
                eb = 1'b1; ed = 1'b0; efc = REP_W'(k / flen);
            end else if (k == total) begin
                ea = 1'b0; eb = 1'b0; ed = 1'b1; efc = REP_W'(r + 1);
            end else begin
                ea = 1'b0; eb = 1'b0; ed = 1'b0; efc = REP_W'(r + 1);
            end
            n_checks++;
            if ({a_out, busy, done, frame_cnt} !== {ea, eb, ed, efc}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: a_out/busy/done/frame_cnt got %b/%b/%b/%0d required %b/%b/%b/%0d",
                         name, k, a_out, busy, done, frame_cnt, ea, eb, ed, efc);
            end
            busy_n += (busy === 1'b1) ? 1 : 0;
            done_n += (done === 1'b1) ? 1 : 0;
            abort = (k == k_ab);
            if (noise == 1 && k + 1 < quiet) begin
                start      = 1'($urandom_range(0, 1));
                hold_len   = HOLD_W'($urandom_range(0, 15));
                repeat_cnt = REP_W'($urandom_range(0, 255));
            end else if (noise == 2 && k + 1 < quiet) begin
                start      = 1'b1;
                hold_len   = 4'd7;
                repeat_cnt = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy_n != ((k_ab >= 0) ? k_ab + 1 : total)) begin
            n_fail++;
            $display("FAIL %s busy_cycles got %0d required %0d", name, busy_n, (k_ab >= 0) ? k_ab + 1 : total);
        end
        n_checks++;
        if (done_n != ((k_ab >= 0) ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s done_pulses got %0d required %0d", name, done_n, (k_ab >= 0) ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if ({a_out, busy, done, frame_cnt} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state got %b required 0", {a_out, busy, done, frame_cnt});
        end
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({a_out, busy, done, frame_cnt} !== 11'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle got %b required 0", {a_out, busy, done, frame_cnt});
        end
    endtask

    task automatic test_min_frame();
        exercise_burst(0, 0, -1, 0, "min_frame");
    endtask

    task automatic test_long_repeats();
        exercise_burst(3, 2, -1, 0, "long_repeats");
    endtask

    task automatic test_start_while_busy();
        exercise_burst(1, 1, -1, 2, "start_while_busy");
    endtask

    task automatic test_abort();
        // hold 1: frame 2 P_CLEAR spans cycles 12-13
        exercise_burst(1, 3, 12, 0, "abort_clear");
        exercise_burst(2, 1, 11, 0, "abort_frame_edge");
        // abort in IDLE suppresses start
        hold_len = 4'd0; repeat_cnt = 8'd0;
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({a_out, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_idle a_out/busy/done got %b required 000", {a_out, busy, done});
        end
    endtask

    task automatic test_loopback();
        int hs [2] = '{0, 2};
        foreach (hs[j]) begin
            logic q [$];
            logic rv [$];
            int   rl [$];
            q.delete(); rv.delete(); rl.delete();
            hold_len = HOLD_W'(hs[j]); repeat_cnt = 8'd0; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            for (int i = 0; i < 200 && busy === 1'b1; i++) begin
                q.push_back(a_out);
                @(negedge clock);
            end
            foreach (q[i]) begin
                if (i == 0 || q[i] !== q[i-1]) begin
                    rv.push_back(q[i]);
                    rl.push_back(1);
                end else begin
                    rl[rl.size()-1] = rl[rl.size()-1] + 1;
                end
            end
            n_checks++;
            if (rv.size() != 4 || !(rv[0] === 1'b1 && rv[1] === 1'b0 && rv[2] === 1'b1)) begin
                n_fail++;
                $display("FAIL loopback_f hold=%0d runs got %0d required 4 with 1,0,1 leading", hs[j], rv.size());
            end
            n_checks++;
            if (rv.size() != 4 || rv[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL loopback_g hold=%0d fourth run missing or not 0 (runs %0d)", hs[j], rv.size());
            end
            foreach (rl[i]) begin
                n_checks++;
                if (rl[i] != hs[j] + 1) begin
                    n_fail++;
                    $display("FAIL loopback_len hold=%0d run %0d got %0d required %0d", hs[j], i, rl[i], hs[j] + 1);
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_async_reset();
        hold_len = 4'd2; repeat_cnt = 8'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clock);
        n_checks++;
        if ({a_out, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL async_pre_stop a_out/busy got %b required 01", {a_out, busy});
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({a_out, busy, done, frame_cnt} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset got %b required 0", {a_out, busy, done, frame_cnt});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        exercise_burst(0, 0, -1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic ea, eb, ed;
        logic [REP_W-1:0] efc;
        hold_len = 4'd0; repeat_cnt = 8'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            n_checks++;
            if ({a_out, busy, done, frame_cnt} !== {k < 4 && (k % 2 == 0), k < 4, k == 4, REP_W'(k == 4)}) begin
                n_fail++;
                $display("FAIL b2b_first cycle %0d got %b/%b/%b/%0d", k, a_out, busy, done, frame_cnt);
            end
            if (k == 4) begin
                hold_len = 4'd1; repeat_cnt = 8'd1; start = 1'b1;
            end
            @(negedge clock);
        end
        start = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            ea  = (k < 16) && (((k % 8) / 2) % 2 == 0);
            eb  = k < 16;
            ed  = k == 16;
            efc = (k < 16) ? REP_W'(k / 8) : 8'd2;
            n_checks++;
            if ({a_out, busy, done, frame_cnt} !== {ea, eb, ed, efc}) begin
                n_fail++;
                $display("FAIL b2b_second cycle %0d got %b/%b/%b/%0d required %b/%b/%b/%0d",
                         k, a_out, busy, done, frame_cnt, ea, eb, ed, efc);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int h, r, total, k_ab;
            h = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            total = (r + 1) * 4 * (h + 1);
            k_ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, total - 1) : -1;
            exercise_burst(h, r, k_ab, 1, "random");
        end
    endtask

    task automatic test_max();
        exercise_burst(15, 255, -1, 0, "max_hold_repeat");
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_long_repeats();
        test_start_while_busy();
        test_abort();
        test_loopback();
        test_async_reset();
        test_back_to_back();
        test_random();
        test_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before test sequence completed");
        $fatal(1);
    end

endmodule

// File: doc/fsm_pattern_gen.md
Name: fsm_pattern_gen

Overview:
- Transmitter counterpart to the serial sequence-detector FSM (Idle/Start/Stop/Clear on line `a`).
- Drives the serial line with the 1-0-1-0 framing that the detector consumes. Phase lengths and frame count are programmable.
- Sits upstream of the detector in the LDPC-small control path. Also serves as the stimulus source for detector regression.

Parameters:
- HOLD_W, 4, width of the per-phase hold length field.
- REP_W, 8, width of the repeat count and frame counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a burst; sampled only in IDLE.
- abort  input  1  synchronous abort; overrides everything except reset.
- hold_len  input  HOLD_W  phase length minus one; latched on accepted start.
- repeat_cnt  input  REP_W  number of frames minus one; latched on accepted start.
- a_out  output  1  registered serial pattern to the detector's `a` input.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse on normal burst completion.
- frame_cnt  output  REP_W  frames fully completed in the current or last burst.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; a_out=0, busy=0, done=0, frame_cnt=0.
  - Internal hold_q, rep_q and phase counter cnt all clear to 0.
- States: IDLE, P_START (a_out=1), P_STOP (a_out=0), P_CLEAR (a_out=1), P_TAIL (a_out=0).
  - a_out is registered. It reflects the state entered at the same clock edge.
- IDLE:
  - a_out=0, busy=0.
  - start=1 and abort=0 at an edge: latch hold_q=hold_len and rep_q=repeat_cnt, clear frame_cnt.
  - At that same edge: cnt=0, state=P_START, a_out=1, busy=1.
  - Latency from start sampled to first a_out=1 is one cycle.
- Phase timing:
  - Each phase lasts exactly hold_q+1 cycles.
  - cnt is 0 on phase entry and increments each cycle.
  - When cnt==hold_q, the next edge advances the phase and reloads cnt=0.
  - Phase order: P_START -> P_STOP -> P_CLEAR -> P_TAIL.
  - Frame length is 4*(hold_q+1) cycles.
- End of P_TAIL:
  - frame_cnt increments (wraps modulo 2^REP_W; cannot exceed rep_q+1 within a burst).
  - If frame_cnt (pre-increment) == rep_q: state=IDLE, a_out=0, busy=0, done=1 for exactly one cycle.
  - Otherwise: state=P_START directly, a_out=1, with no idle gap between frames.
- start while busy=1: ignored. Latched hold_q and rep_q are unchanged.
- hold_len and repeat_cnt changes after acceptance have no effect until the next accepted start.
- abort=1 at any edge with state != IDLE:
  - state=IDLE, a_out=0, busy=0, cnt=0.
  - done stays 0; frame_cnt holds its value.
  - abort has priority over phase advance and over start in the same cycle.
- abort=1 in IDLE: no effect, and start is suppressed.
- done asserts only on normal completion. It is never asserted together with busy=1.
- start=1 in the same cycle done=1 (state IDLE): accepted normally. Back-to-back bursts are possible with a one-cycle gap.
- hold_len=0: each phase is one cycle, giving a_out=1,0,1,0.
- Max hold_len (2^HOLD_W-1): each phase is 2^HOLD_W cycles.
- repeat_cnt=0: one frame.
- Max repeat_cnt: 2^REP_W frames; frame_cnt wraps to 0 on the final increment.
- reset asserted mid-burst: immediate return to the reset values above. No done pulse.

Test Plan:
- Single minimal frame: hold_len=0, repeat_cnt=0, start pulsed in cycle 0 -> a_out=1,0,1,0 in cycles 1-4; busy=1 in cycles 1-4; done=1 only in cycle 5; frame_cnt=1.
- Long phases with repeats: hold_len=3, repeat_cnt=2 -> a_out holds 4 cycles per phase; 3 frames = 48 busy cycles with no gap between frames; done once; frame_cnt=3.
- Start while busy and input changes: mid-burst start=1 and hold_len=7 -> no restart; phase lengths stay per the latched value.
- Abort in P_CLEAR of frame 2 (repeat_cnt=3) -> next cycle a_out=0, busy=0, done never pulses, frame_cnt=1.
- Loopback into detector FSM: hold_len=0 -> detector f=1 after the third bit and g=1 after the fourth; hold_len=2 -> same f/g outcome.
- Async reset mid-P_STOP -> all outputs 0 immediately, without waiting for a clock edge; then start after reset release -> a full clean frame.
